// File: rtl/arb81_32bit.sv
// arb81_32bit: 8:1 arbitrated 32-bit data mux with a valid/ready output.
// Ports: clk, rst_n, req[7:0], ain..hin[31:0] in; out, out_valid, grant, control, xfer_count out; out_ready in.
module arb81_32bit #(
   parameter int PRIORITY_MODE = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  req,
   input  logic [31:0] ain,
   input  logic [31:0] bin,
   input  logic [31:0] cin,
   input  logic [31:0] din,
   input  logic [31:0] ein,
   input  logic [31:0] fin,
   input  logic [31:0] gin,
   input  logic [31:0] hin,
   output logic [31:0] out,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  grant,
   output logic [2:0]  control,
   output logic [15:0] xfer_count
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state;
   logic [2:0]  ptr;
   logic [2:0]  sel;
   logic [2:0]  idx;
   logic        found;
   logic        load;
   logic [31:0] mux;

   // Index 8 wraps to ptr itself, so the last requester served is
   // scanned last.
   always_comb begin
      sel   = '0;
      idx   = '0;
      found = 1'b0;
      if (PRIORITY_MODE != 0) begin
         for (int i = 7; i >= 0; i--) begin
            if (req[i]) sel = 3'(i);
         end
      end else begin
         for (int i = 1; i <= 8; i++) begin
            idx = ptr + 3'(i);
            if (!found && req[idx]) begin
               sel   = idx;
               found = 1'b1;
            end
         end
      end
   end

   always_comb begin
      mux = ain;
      unique case (sel)
         3'd0: mux = ain;
         3'd1: mux = bin;
         3'd2: mux = cin;
         3'd3: mux = din;
         3'd4: mux = ein;
         3'd5: mux = fin;
         3'd6: mux = gin;
         3'd7: mux = hin;
         default: mux = ain;
      endcase
   end

   // Gated by rst_n so grant is forced low while reset is held.
   assign load  = rst_n && (|req) && (state == IDLE || out_ready);
   assign grant = load ? (8'b1 << sel) : 8'h00;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         out        <= '0;
         out_valid  <= 1'b0;
         control    <= '0;
         xfer_count <= '0;
         ptr        <= 3'd7;
      end else begin
         if (out_valid && out_ready)
            xfer_count <= xfer_count + 16'd1;
         if (load) begin
            state     <= BUSY;
            out       <= mux;
            out_valid <= 1'b1;
            control   <= sel;
            ptr       <= sel;
         end else if (state == BUSY && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_arb81_32bit.sv
// tb_arb81_32bit: scoreboard bench for arb81_32bit.
// Round-robin and fixed-priority instances share one stimulus.
module tb_arb81_32bit;

   typedef struct {
      logic [31:0] data;
      logic [2:0]  ctrl;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [7:0]  req;
   logic [31:0] d [8];
   logic        out_ready;

   logic [31:0] out_r, out_f;
   logic        val_r, val_f;
   logic [7:0]  gnt_r, gnt_f;
   logic [2:0]  ctl_r, ctl_f;
   logic [15:0] cnt_r, cnt_f;

   exp_t q[$];
   int   nvec = 0;
   int   nerr = 0;

   arb81_32bit #(.PRIORITY_MODE(0)) dut_rr (
      .clk(clk), .rst_n(rst_n), .req(req),
      .ain(d[0]), .bin(d[1]), .cin(d[2]), .din(d[3]),
      .ein(d[4]), .fin(d[5]), .gin(d[6]), .hin(d[7]),
      .out(out_r), .out_valid(val_r), .out_ready(out_ready),
      .grant(gnt_r), .control(ctl_r), .xfer_count(cnt_r)
   );

   arb81_32bit #(.PRIORITY_MODE(1)) dut_fp (
      .clk(clk), .rst_n(rst_n), .req(req),
      .ain(d[0]), .bin(d[1]), .cin(d[2]), .din(d[3]),
      .ein(d[4]), .fin(d[5]), .gin(d[6]), .hin(d[7]),
      .out(out_f), .out_valid(val_f), .out_ready(out_ready),
      .grant(gnt_f), .control(ctl_f), .xfer_count(cnt_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] a,
                      input logic [31:0] e);
      nvec++;
      if (a !== e) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, a, e);
      end
   endtask

   task automatic push(input logic [31:0] dat, input logic [2:0] c);
      exp_t e;
      e.data = dat;
      e.ctrl = c;
      q.push_back(e);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req = 8'h00;
      rst_n = 1'b0;
      q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Monitor: every accepted word is popped and compared.
   always @(negedge clk) begin
      if (rst_n && val_r && out_ready) begin
         if (q.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL sb_empty: got word %h expected none", out_r);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("sb_out", out_r, e.data);
            chk("sb_ctrl", 32'(ctl_r), 32'(e.ctrl));
         end
      end
   end

   initial begin
      logic [2:0] rr_seq [4];
      rr_seq = '{3'd2, 3'd7, 3'd2, 3'd7};
      for (int i = 0; i < 8; i++) d[i] = 32'hA000_0000 + 32'(i);
      out_ready = 1'b1;
      do_reset();

      // reset state
      @(negedge clk);
      chk("rst_out", out_r, 32'h0);
      chk("rst_valid", 32'(val_r), 32'h0);
      chk("rst_ctrl", 32'(ctl_r), 32'h0);
      chk("rst_grant", 32'(gnt_r), 32'h0);
      chk("rst_count", 32'(cnt_r), 32'h0);

      // single transfer
      cyc();
      d[0] = 32'hDEADBEEF;
      req = 8'h01;
      push(32'hDEADBEEF, 3'd0);
      @(negedge clk);
      chk("t1_grant", 32'(gnt_r), 32'h01);
      cyc();
      req = 8'h00;
      @(negedge clk);
      chk("t1_valid", 32'(val_r), 32'h1);
      chk("t1_ctrl", 32'(ctl_r), 32'h0);
      cyc();
      @(negedge clk);
      chk("t1_count", 32'(cnt_r), 32'h1);
      chk("t1_idle", 32'(val_r), 32'h0);

      // round robin, all requesting
      do_reset();
      req = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         push(d[i % 8], 3'(i % 8));
         @(negedge clk);
         chk("rr_grant", 32'(gnt_r), 32'(8'h01 << (i % 8)));
         if (i > 0) chk("rr_nogap", 32'(val_r), 32'h1);
         cyc();
      end
      req = 8'h00;
      cyc();
      cyc();
      chk("rr_count", 32'(cnt_r), 32'd9);

      // fixed priority vs round robin on req=0x84
      do_reset();
      req = 8'h84;
      for (int i = 0; i < 4; i++) begin
         push(d[rr_seq[i]], rr_seq[i]);
         @(negedge clk);
         chk("fp_grant", 32'(gnt_f), 32'h04);
         chk("rr84_grant", 32'(gnt_r), 32'(8'h01 << rr_seq[i]));
         if (i > 0) chk("fp_ctrl", 32'(ctl_f), 32'h2);
         cyc();
      end
      req = 8'h00;
      cyc();
      cyc();
      chk("fp_count", 32'(cnt_f), 32'd4);

      // back-pressure
      do_reset();
      out_ready = 1'b0;
      d[0] = 32'h1111_1111;
      req = 8'h01;
      push(32'h1111_1111, 3'd0);
      @(negedge clk);
      chk("bp_grant0", 32'(gnt_r), 32'h01);
      for (int i = 0; i < 5; i++) begin
         cyc();
         req = 8'(8'h03 << i);
         for (int j = 0; j < 8; j++) d[j] = $urandom;
         @(negedge clk);
         chk("bp_grant", 32'(gnt_r), 32'h0);
         chk("bp_out", out_r, 32'h1111_1111);
         chk("bp_ctrl", 32'(ctl_r), 32'h0);
         chk("bp_valid", 32'(val_r), 32'h1);
      end
      cyc();
      out_ready = 1'b1;
      req = 8'h02;
      d[1] = 32'h2222_2222;
      push(32'h2222_2222, 3'd1);
      @(negedge clk);
      chk("bp_release", 32'(gnt_r), 32'h02);
      cyc();
      req = 8'h00;
      cyc();
      cyc();
      chk("bp_count", 32'(cnt_r), 32'd2);

      // reset in the middle of BUSY
      do_reset();
      req = 8'h01;
      for (int i = 0; i < 4; i++) begin
         d[0] = 32'hC000_0000 + 32'(i);
         push(d[0], 3'd0);
         cyc();
      end
      out_ready = 1'b0;
      req = 8'h00;
      @(negedge clk);
      chk("mr_count", 32'(cnt_r), 32'd3);
      chk("mr_busy", 32'(val_r), 32'h1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      q.delete();
      #1;
      chk("mr_out", out_r, 32'h0);
      chk("mr_valid", 32'(val_r), 32'h0);
      chk("mr_ctrl", 32'(ctl_r), 32'h0);
      chk("mr_grant", 32'(gnt_r), 32'h0);
      chk("mr_cnt0", 32'(cnt_r), 32'h0);
      rst_n = 1'b1;
      out_ready = 1'b1;
      req = 8'h80;
      d[7] = 32'h7777_7777;
      push(32'h7777_7777, 3'd7);
      @(negedge clk);
      chk("mr_grant7", 32'(gnt_r), 32'h80);
      cyc();
      req = 8'h00;
      @(negedge clk);
      chk("mr_ctrl7", 32'(ctl_r), 32'h7);
      cyc();
      cyc();

      // counter wrap
      do_reset();
      d[0] = 32'h5A5A_0000;
      req = 8'h01;
      for (int n = 0; n < 65535; n++) begin
         push(32'h5A5A_0000, 3'd0);
         cyc();
      end
      req = 8'h00;
      cyc();
      cyc();
      chk("wrap_ffff", 32'(cnt_r), 32'h0000_FFFF);
      req = 8'h01;
      push(32'h5A5A_0000, 3'd0);
      cyc();
      req = 8'h00;
      cyc();
      cyc();
      chk("wrap_zero", 32'(cnt_r), 32'h0);

      chk("sb_drained", 32'(q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
